// File: rtl/ysyx_22050550_axi_pkg.sv
// Shared definitions for the two-master AXI arbiter: FSM encodings, AXI
// size/burst constants and a small lane-select helper.
package ysyx_22050550_axi_pkg;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_BUSY = 1'b1
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam int LEN_W = 8;

  // Each master owns one LEN_W slice of the packed len bus.
  function automatic logic [LEN_W-1:0] pick_len(input logic sel,
                                                input logic [2*LEN_W-1:0] lens);
    return sel ? lens[2*LEN_W-1:LEN_W] : lens[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/ysyx_22050550_rr_arb2.sv
// Two-request arbiter: a lone requester wins outright, a tie goes to prio.
module ysyx_22050550_rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_22050550_axi_arbiter.sv
// Two-master to one-SRAM-slave AXI arbiter; independent read and write paths
// so a read burst and a write burst can be in flight at the same time.
module ysyx_22050550_axi_arbiter
  import ysyx_22050550_axi_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  // master read address
  input  logic [1:0]            io_m_ar_valid,
  input  logic [2*ADDR_W-1:0]   io_m_ar_addr,
  input  logic [15:0]           io_m_ar_len,
  input  logic [5:0]            io_m_ar_size,
  input  logic [3:0]            io_m_ar_burst,
  output logic [1:0]            io_m_ar_ready,
  // master read data
  output logic [1:0]            io_m_r_valid,
  output logic [DATA_W-1:0]     io_m_r_data,
  output logic                  io_m_r_last,
  input  logic [1:0]            io_m_r_ready,
  // master write address
  input  logic [1:0]            io_m_aw_valid,
  input  logic [2*ADDR_W-1:0]   io_m_aw_addr,
  input  logic [15:0]           io_m_aw_len,
  input  logic [5:0]            io_m_aw_size,
  input  logic [3:0]            io_m_aw_burst,
  output logic [1:0]            io_m_aw_ready,
  // master write data
  input  logic [1:0]            io_m_w_valid,
  input  logic [2*DATA_W-1:0]   io_m_w_data,
  input  logic [2*DATA_W/8-1:0] io_m_w_strb,
  input  logic [1:0]            io_m_w_last,
  output logic [1:0]            io_m_w_ready,
  // master write response
  output logic [1:0]            io_m_b_valid,
  input  logic [1:0]            io_m_b_ready,
  // slave read address
  output logic                  io_Sram_ar_valid,
  input  logic                  io_Sram_ar_ready,
  output logic [ADDR_W-1:0]     io_Sram_ar_addr,
  output logic [7:0]            io_ar_len,
  output logic [2:0]            io_ar_size,
  output logic [1:0]            io_ar_burst,
  // slave read data
  input  logic                  io_Sram_r_valid,
  output logic                  io_Sram_r_ready,
  input  logic [DATA_W-1:0]     io_Sram_r_data,
  input  logic                  io_Sram_r_last,
  // slave write address
  output logic                  io_Sram_aw_valid,
  input  logic                  io_Sram_aw_ready,
  output logic [ADDR_W-1:0]     io_Sram_aw_addr,
  output logic [7:0]            io_aw_len,
  output logic [2:0]            io_aw_size,
  output logic [1:0]            io_aw_burst,
  // slave write data
  output logic                  io_Sram_w_valid,
  input  logic                  io_Sram_w_ready,
  output logic [DATA_W-1:0]     io_Sram_w_data,
  output logic [DATA_W/8-1:0]   io_Sram_w_strb,
  output logic                  io_Sram_w_last,
  // sticky protocol error
  output logic                  io_err
);

  localparam int STRB_W = DATA_W / 8;

  // ---------------------------------------------------------------- read path
  r_state_t   r_state, r_state_nxt;
  logic       rowner, rprio;
  logic [1:0] r_grant;
  logic       r_win;
  logic       ar_hs, r_last_hs;

  ysyx_22050550_rr_arb2 u_r_arb (
    .req   (io_m_ar_valid),
    .prio  (rprio),
    .grant (r_grant)
  );

  assign r_win = r_grant[1];

  // Address-side fields follow the current winner; they only matter while valid.
  assign io_Sram_ar_addr = r_win ? io_m_ar_addr[2*ADDR_W-1:ADDR_W] : io_m_ar_addr[ADDR_W-1:0];
  assign io_ar_len       = pick_len(r_win, io_m_ar_len);
  assign io_ar_size      = r_win ? io_m_ar_size[5:3]  : io_m_ar_size[2:0];
  assign io_ar_burst     = r_win ? io_m_ar_burst[3:2] : io_m_ar_burst[1:0];
  assign io_m_r_data     = io_Sram_r_data;
  assign io_m_r_last     = io_Sram_r_last;

  always_comb begin
    r_state_nxt      = r_state;
    io_Sram_ar_valid = 1'b0;
    io_m_ar_ready    = 2'b00;
    io_m_r_valid     = 2'b00;
    io_Sram_r_ready  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        io_Sram_ar_valid = |io_m_ar_valid;
        io_m_ar_ready    = r_grant & {2{io_Sram_ar_ready}};
        if (io_Sram_ar_valid && io_Sram_ar_ready) r_state_nxt = R_BUSY;
      end
      R_BUSY: begin
        io_m_r_valid[rowner] = io_Sram_r_valid;
        io_Sram_r_ready      = io_m_r_ready[rowner];
        if (io_Sram_r_valid && io_Sram_r_ready && io_Sram_r_last) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign ar_hs     = (r_state == R_IDLE) && io_Sram_ar_valid && io_Sram_ar_ready;
  assign r_last_hs = (r_state == R_BUSY) && io_Sram_r_valid && io_Sram_r_ready && io_Sram_r_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= R_IDLE;
      rowner  <= 1'b0;
      rprio   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_state <= r_state_nxt;
      if (ar_hs)     rowner <= r_win;
      if (r_last_hs) rprio  <= ~rowner;
    end
  end

  // --------------------------------------------------------------- write path
  w_state_t   w_state, w_state_nxt;
  logic       wowner, wprio;
  logic [1:0] w_grant;
  logic       w_win;
  logic [7:0] wcnt;
  logic       aw_hs, w_hs, w_end, b_hs;

  ysyx_22050550_rr_arb2 u_w_arb (
    .req   (io_m_aw_valid),
    .prio  (wprio),
    .grant (w_grant)
  );

  assign w_win = w_grant[1];

  assign io_Sram_aw_addr = w_win ? io_m_aw_addr[2*ADDR_W-1:ADDR_W] : io_m_aw_addr[ADDR_W-1:0];
  assign io_aw_len       = pick_len(w_win, io_m_aw_len);
  assign io_aw_size      = w_win ? io_m_aw_size[5:3]  : io_m_aw_size[2:0];
  assign io_aw_burst     = w_win ? io_m_aw_burst[3:2] : io_m_aw_burst[1:0];
  assign io_Sram_w_data  = wowner ? io_m_w_data[2*DATA_W-1:DATA_W] : io_m_w_data[DATA_W-1:0];
  assign io_Sram_w_strb  = wowner ? io_m_w_strb[2*STRB_W-1:STRB_W] : io_m_w_strb[STRB_W-1:0];

  // The beat counter, not the master's w_last, decides where the burst ends.
  assign w_end = (wcnt == 8'd0);

  always_comb begin
    w_state_nxt      = w_state;
    io_Sram_aw_valid = 1'b0;
    io_m_aw_ready    = 2'b00;
    io_Sram_w_valid  = 1'b0;
    io_Sram_w_last   = 1'b0;
    io_m_w_ready     = 2'b00;
    io_m_b_valid     = 2'b00;
    unique case (w_state)
      W_IDLE: begin
        io_Sram_aw_valid = |io_m_aw_valid;
        io_m_aw_ready    = w_grant & {2{io_Sram_aw_ready}};
        if (io_Sram_aw_valid && io_Sram_aw_ready) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        io_Sram_w_valid      = io_m_w_valid[wowner];
        io_Sram_w_last       = w_end;
        io_m_w_ready[wowner] = io_Sram_w_ready;
        if (io_Sram_w_valid && io_Sram_w_ready && w_end) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        io_m_b_valid[wowner] = 1'b1;
        if (io_m_b_ready[wowner]) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign aw_hs = (w_state == W_IDLE) && io_Sram_aw_valid && io_Sram_aw_ready;
  assign w_hs  = (w_state == W_DATA) && io_Sram_w_valid && io_Sram_w_ready;
  assign b_hs  = (w_state == W_RESP) && io_m_b_ready[wowner];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state <= W_IDLE;
      wowner  <= 1'b0;
      wprio   <= 1'b0;
      wcnt    <= 8'd0;
      io_err  <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      if (aw_hs) begin
        wowner <= w_win;
        wcnt   <= io_aw_len;
      end else if (w_hs && !w_end) begin
        wcnt <= wcnt - 8'd1;
      end
      if (w_hs && (io_m_w_last[wowner] != w_end)) io_err <= 1'b1;
      if (b_hs) wprio <= ~wowner;
    end
  end

endmodule

// File: tb/tb_ysyx_22050550_axi_arbiter.sv
// Directed bench for the two-master AXI arbiter: an idle-arbitration vector
// table followed by hand-written burst, concurrency, error and reset sequences.
module tb_ysyx_22050550_axi_arbiter;
  import ysyx_22050550_axi_pkg::*;

  logic         clock, reset;
  logic [1:0]   io_m_ar_valid, io_m_ar_ready;
  logic [127:0] io_m_ar_addr;
  logic [15:0]  io_m_ar_len;
  logic [5:0]   io_m_ar_size;
  logic [3:0]   io_m_ar_burst;
  logic [1:0]   io_m_r_valid, io_m_r_ready;
  logic [63:0]  io_m_r_data;
  logic         io_m_r_last;
  logic [1:0]   io_m_aw_valid, io_m_aw_ready;
  logic [127:0] io_m_aw_addr;
  logic [15:0]  io_m_aw_len;
  logic [5:0]   io_m_aw_size;
  logic [3:0]   io_m_aw_burst;
  logic [1:0]   io_m_w_valid, io_m_w_last, io_m_w_ready;
  logic [127:0] io_m_w_data;
  logic [15:0]  io_m_w_strb;
  logic [1:0]   io_m_b_valid, io_m_b_ready;
  logic         io_Sram_ar_valid, io_Sram_ar_ready;
  logic [63:0]  io_Sram_ar_addr;
  logic [7:0]   io_ar_len;
  logic [2:0]   io_ar_size;
  logic [1:0]   io_ar_burst;
  logic         io_Sram_r_valid, io_Sram_r_ready, io_Sram_r_last;
  logic [63:0]  io_Sram_r_data;
  logic         io_Sram_aw_valid, io_Sram_aw_ready;
  logic [63:0]  io_Sram_aw_addr;
  logic [7:0]   io_aw_len;
  logic [2:0]   io_aw_size;
  logic [1:0]   io_aw_burst;
  logic         io_Sram_w_valid, io_Sram_w_ready, io_Sram_w_last;
  logic [63:0]  io_Sram_w_data;
  logic [7:0]   io_Sram_w_strb;
  logic         io_err;

  int checks   = 0;
  int failures = 0;

  ysyx_22050550_axi_arbiter dut (
    .clock(clock), .reset(reset),
    .io_m_ar_valid(io_m_ar_valid), .io_m_ar_addr(io_m_ar_addr), .io_m_ar_len(io_m_ar_len),
    .io_m_ar_size(io_m_ar_size), .io_m_ar_burst(io_m_ar_burst), .io_m_ar_ready(io_m_ar_ready),
    .io_m_r_valid(io_m_r_valid), .io_m_r_data(io_m_r_data), .io_m_r_last(io_m_r_last),
    .io_m_r_ready(io_m_r_ready),
    .io_m_aw_valid(io_m_aw_valid), .io_m_aw_addr(io_m_aw_addr), .io_m_aw_len(io_m_aw_len),
    .io_m_aw_size(io_m_aw_size), .io_m_aw_burst(io_m_aw_burst), .io_m_aw_ready(io_m_aw_ready),
    .io_m_w_valid(io_m_w_valid), .io_m_w_data(io_m_w_data), .io_m_w_strb(io_m_w_strb),
    .io_m_w_last(io_m_w_last), .io_m_w_ready(io_m_w_ready),
    .io_m_b_valid(io_m_b_valid), .io_m_b_ready(io_m_b_ready),
    .io_Sram_ar_valid(io_Sram_ar_valid), .io_Sram_ar_ready(io_Sram_ar_ready),
    .io_Sram_ar_addr(io_Sram_ar_addr), .io_ar_len(io_ar_len), .io_ar_size(io_ar_size),
    .io_ar_burst(io_ar_burst),
    .io_Sram_r_valid(io_Sram_r_valid), .io_Sram_r_ready(io_Sram_r_ready),
    .io_Sram_r_data(io_Sram_r_data), .io_Sram_r_last(io_Sram_r_last),
    .io_Sram_aw_valid(io_Sram_aw_valid), .io_Sram_aw_ready(io_Sram_aw_ready),
    .io_Sram_aw_addr(io_Sram_aw_addr), .io_aw_len(io_aw_len), .io_aw_size(io_aw_size),
    .io_aw_burst(io_aw_burst),
    .io_Sram_w_valid(io_Sram_w_valid), .io_Sram_w_ready(io_Sram_w_ready),
    .io_Sram_w_data(io_Sram_w_data), .io_Sram_w_strb(io_Sram_w_strb),
    .io_Sram_w_last(io_Sram_w_last),
    .io_err(io_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    io_m_ar_valid = '0; io_m_ar_addr = '0; io_m_ar_len = '0; io_m_ar_size = '0;
    io_m_ar_burst = {AXI_BURST_INCR, AXI_BURST_INCR}; io_m_r_ready = '0;
    io_m_aw_valid = '0; io_m_aw_addr = '0; io_m_aw_len = '0; io_m_aw_size = '0;
    io_m_aw_burst = {AXI_BURST_INCR, AXI_BURST_INCR};
    io_m_w_valid = '0; io_m_w_data = '0; io_m_w_strb = '0; io_m_w_last = '0;
    io_m_b_ready = '0; io_Sram_ar_ready = 1'b0; io_Sram_r_valid = 1'b0;
    io_Sram_r_data = '0; io_Sram_r_last = 1'b0; io_Sram_aw_ready = 1'b0;
    io_Sram_w_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Slave supplies beats of a read burst of total length 'total'; checks routing.
  task automatic read_beats(input int owner, input int total, input int count, input string tag);
    for (int k = 0; k < count; k++) begin
      @(negedge clock);
      io_Sram_r_valid = 1'b1;
      io_Sram_r_data  = 64'hD000 + 64'(k);
      io_Sram_r_last  = (k == total - 1);
      io_m_r_ready    = 2'b01 << owner;
      #1;
      check({tag, " r_valid"}, io_m_r_valid, 2'b01 << owner);
      check({tag, " r_data"}, io_m_r_data, 64'hD000 + 64'(k));
      check({tag, " r_last"}, io_m_r_last, (k == total - 1));
      check({tag, " sram r_ready"}, io_Sram_r_ready, 1'b1);
      check({tag, " ar blocked"}, {io_Sram_ar_valid, io_m_ar_ready}, 3'b000);
    end
  endtask

  task automatic write_beat(input int owner, input int k, input logic last, input logic exp_slast,
                            input string tag);
    @(negedge clock);
    io_m_w_valid    = 2'b01 << owner;
    io_m_w_data     = {64'hB100 + 64'(k), 64'hA100 + 64'(k)};
    io_m_w_strb     = {8'hF0, 8'h0F};
    io_m_w_last     = 2'(last) << owner;
    io_Sram_w_ready = 1'b1;
    #1;
    check({tag, " sram w_valid"}, io_Sram_w_valid, 1'b1);
    check({tag, " w_data"}, io_Sram_w_data, (owner == 1) ? 64'hB100 + 64'(k) : 64'hA100 + 64'(k));
    check({tag, " w_strb"}, io_Sram_w_strb, (owner == 1) ? 8'hF0 : 8'h0F);
    check({tag, " m w_ready"}, io_m_w_ready, 2'b01 << owner);
    check({tag, " sram w_last"}, io_Sram_w_last, exp_slast);
    check({tag, " aw_ready blocked"}, io_m_aw_ready, 2'b00);
  endtask

  typedef struct {
    logic [1:0]  arv;
    logic        sar_rdy;
    logic [1:0]  awv;
    logic        saw_rdy;
    logic        exp_sarv;
    logic [1:0]  exp_arr;
    logic [63:0] exp_araddr;
    logic        exp_sawv;
    logic [1:0]  exp_awr;
    logic [7:0]  exp_awlen;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 64'h1000, 1'b0, 2'b00, 8'd5};
    vecs[1] = '{2'b01, 1'b1, 2'b10, 1'b1, 1'b1, 2'b01, 64'h1000, 1'b1, 2'b10, 8'd9};
    vecs[2] = '{2'b10, 1'b1, 2'b01, 1'b0, 1'b1, 2'b10, 64'h2000, 1'b1, 2'b00, 8'd5};
    vecs[3] = '{2'b11, 1'b1, 2'b11, 1'b1, 1'b1, 2'b01, 64'h1000, 1'b1, 2'b01, 8'd5};
    vecs[4] = '{2'b11, 1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 64'h1000, 1'b1, 2'b00, 8'd9};
    vecs[5] = '{2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 64'h2000, 1'b0, 2'b00, 8'd5};

    // Reset state, with stray slave/master activity that must not leak through.
    do_reset();
    reset = 1'b0;
    io_Sram_r_valid = 1'b1;
    io_m_w_valid    = 2'b11;
    #1;
    check("rst r_valid", io_m_r_valid, 2'b00);
    check("rst b_valid", io_m_b_valid, 2'b00);
    check("rst err", io_err, 1'b0);
    check("rst sram w_valid", io_Sram_w_valid, 1'b0);
    do_reset();

    // Idle arbitration table (both prios at reset value 0).
    io_m_ar_addr = {64'h2000, 64'h1000};
    io_m_ar_len  = {8'd7, 8'd2};
    io_m_aw_addr = {64'h4000, 64'h3000};
    io_m_aw_len  = {8'd9, 8'd5};
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      io_m_ar_valid = vecs[i].arv; io_Sram_ar_ready = vecs[i].sar_rdy;
      io_m_aw_valid = vecs[i].awv; io_Sram_aw_ready = vecs[i].saw_rdy;
      #1;
      check($sformatf("vec%0d sram ar_valid", i), io_Sram_ar_valid, vecs[i].exp_sarv);
      check($sformatf("vec%0d ar_ready", i), io_m_ar_ready, vecs[i].exp_arr);
      if (vecs[i].exp_sarv) check($sformatf("vec%0d ar_addr", i), io_Sram_ar_addr, vecs[i].exp_araddr);
      check($sformatf("vec%0d sram aw_valid", i), io_Sram_aw_valid, vecs[i].exp_sawv);
      check($sformatf("vec%0d aw_ready", i), io_m_aw_ready, vecs[i].exp_awr);
      if (vecs[i].exp_sawv) check($sformatf("vec%0d aw_len", i), io_aw_len, vecs[i].exp_awlen);
      #1;
      io_m_ar_valid = '0; io_m_aw_valid = '0;
    end

    // Single m0 read burst of 4 beats, forwarded in the request cycle.
    do_reset();
    @(negedge clock);
    io_m_ar_valid = 2'b01;
    io_m_ar_addr  = {64'h0, 64'h8000_0000};
    io_m_ar_len   = {8'd0, 8'd3};
    io_m_ar_size  = {AXI_SIZE_1B, AXI_SIZE_8B};
    io_Sram_ar_ready = 1'b1;
    #1;
    check("rd1 sram ar_valid", io_Sram_ar_valid, 1'b1);
    check("rd1 ar_addr", io_Sram_ar_addr, 64'h8000_0000);
    check("rd1 ar_len", io_ar_len, 8'd3);
    check("rd1 ar_size", io_ar_size, AXI_SIZE_8B);
    check("rd1 ar_ready", io_m_ar_ready, 2'b01);
    read_beats(0, 4, 4, "rd1");
    @(negedge clock);
    io_Sram_ar_ready = 1'b0;
    #1;
    check("rd1 idle r_valid", io_m_r_valid, 2'b00);
    check("rd1 idle sram r_ready", io_Sram_r_ready, 1'b0);
    check("rd1 idle ar_valid", io_Sram_ar_valid, 1'b1);

    // Both masters request reads; round-robin hands over after m0's last beat.
    do_reset();
    @(negedge clock);
    io_m_ar_valid = 2'b11;
    io_m_ar_addr  = {64'h2000, 64'h1000};
    io_m_ar_len   = {8'd0, 8'd1};
    io_Sram_ar_ready = 1'b1;
    #1;
    check("rr ar_ready m0", io_m_ar_ready, 2'b01);
    check("rr ar_addr m0", io_Sram_ar_addr, 64'h1000);
    read_beats(0, 2, 2, "rr m0");
    @(negedge clock);
    io_Sram_r_valid = 1'b0;
    #1;
    check("rr ar_ready m1", io_m_ar_ready, 2'b10);
    check("rr ar_addr m1", io_Sram_ar_addr, 64'h2000);
    check("rr ar_len m1", io_ar_len, 8'd0);
    read_beats(1, 1, 1, "rr m1");
    @(negedge clock);
    io_Sram_r_valid = 1'b0;
    #1;
    check("rr prio back to m0", io_m_ar_ready, 2'b01);

    // m1 write len 1, response held three cycles; m0 locked out meanwhile.
    do_reset();
    @(negedge clock);
    io_m_aw_valid = 2'b10;
    io_m_aw_addr  = {64'h4000, 64'h0};
    io_m_aw_len   = {8'd1, 8'd0};
    io_Sram_aw_ready = 1'b1;
    #1;
    check("wr aw_ready", io_m_aw_ready, 2'b10);
    check("wr sram aw_valid", io_Sram_aw_valid, 1'b1);
    check("wr aw_addr", io_Sram_aw_addr, 64'h4000);
    check("wr aw_len", io_aw_len, 8'd1);
    write_beat(1, 0, 1'b0, 1'b0, "wr b0");
    io_m_aw_valid = 2'b01;
    write_beat(1, 1, 1'b1, 1'b1, "wr b1");
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      io_m_w_valid = '0;
      io_m_b_ready = (c == 3) ? 2'b10 : 2'b00;
      if (c == 3) io_m_aw_valid = '0;
      #1;
      check($sformatf("wr resp%0d b_valid", c), io_m_b_valid, 2'b10);
      check($sformatf("wr resp%0d aw_ready", c), io_m_aw_ready, 2'b00);
    end
    @(negedge clock);
    io_m_b_ready = '0;
    #1;
    check("wr done b_valid", io_m_b_valid, 2'b00);
    check("wr err", io_err, 1'b0);

    // Concurrent m0 read (len 3) and m1 write (len 0).
    do_reset();
    @(negedge clock);
    io_m_ar_valid = 2'b01; io_m_ar_addr = {64'h0, 64'h5000}; io_m_ar_len = {8'd0, 8'd3};
    io_m_aw_valid = 2'b10; io_m_aw_addr = {64'h6000, 64'h0}; io_m_aw_len = {8'd0, 8'd0};
    io_Sram_ar_ready = 1'b1; io_Sram_aw_ready = 1'b1; io_m_b_ready = 2'b10;
    #1;
    check("cc ar_ready", io_m_ar_ready, 2'b01);
    check("cc aw_ready", io_m_aw_ready, 2'b10);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      io_m_ar_valid = '0; io_m_aw_valid = '0;
      io_Sram_r_valid = 1'b1; io_Sram_r_data = 64'hE000 + 64'(c); io_Sram_r_last = (c == 3);
      io_m_r_ready = 2'b01;
      io_m_w_valid = (c == 0) ? 2'b10 : 2'b00;
      io_m_w_last  = (c == 0) ? 2'b10 : 2'b00;
      io_m_w_data  = {64'hCAFE, 64'h0};
      io_Sram_w_ready = 1'b1;
      #1;
      check($sformatf("cc%0d r_valid", c), io_m_r_valid, 2'b01);
      check($sformatf("cc%0d r_data", c), io_m_r_data, 64'hE000 + 64'(c));
      check($sformatf("cc%0d sram w_valid", c), io_Sram_w_valid, (c == 0));
      if (c == 0) check("cc0 w_data", io_Sram_w_data, 64'hCAFE);
      check($sformatf("cc%0d b_valid", c), io_m_b_valid, (c == 1) ? 2'b10 : 2'b00);
    end

    // w_last on the wrong beat sets the sticky error; burst length unchanged.
    do_reset();
    @(negedge clock);
    io_m_aw_valid = 2'b10; io_m_aw_len = {8'd1, 8'd0}; io_Sram_aw_ready = 1'b1;
    write_beat(1, 0, 1'b1, 1'b0, "err b0");
    io_m_aw_valid = '0;
    write_beat(1, 1, 1'b0, 1'b1, "err b1");
    check("err set", io_err, 1'b1);
    @(negedge clock);
    io_m_w_valid = '0; io_m_b_ready = 2'b10;
    #1;
    check("err b_valid", io_m_b_valid, 2'b10);
    repeat (3) @(negedge clock);
    io_m_b_ready = '0;
    #1;
    check("err sticky", io_err, 1'b1);
    reset = 1'b0;
    #1;
    check("err cleared", io_err, 1'b0);

    // Reset during beat 2 of a len 3 read.
    do_reset();
    @(negedge clock);
    io_m_ar_valid = 2'b01; io_m_ar_len = {8'd0, 8'd3}; io_Sram_ar_ready = 1'b1;
    read_beats(0, 4, 1, "rst rd");
    io_m_ar_valid = '0;
    @(negedge clock);
    io_Sram_r_valid = 1'b1; io_Sram_r_last = 1'b0; io_m_r_ready = 2'b01;
    #1;
    check("rst rd beat2 r_valid", io_m_r_valid, 2'b01);
    reset = 1'b0;
    #1;
    check("rst rd r_valid", io_m_r_valid, 2'b00);
    check("rst rd sram r_ready", io_Sram_r_ready, 1'b0);
    check("rst rd ar_ready", io_m_ar_ready, 2'b00);
    check("rst rd b_valid", io_m_b_valid, 2'b00);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      check($sformatf("post rst%0d r_valid", c), io_m_r_valid, 2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22050550_axi_arbiter.md
YSYX_22050550_AXI_ARBITER -- requirements
Module: ysyx_22050550_axi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width of every ar/aw address.
REQ-002 SHALL have parameter DATA_W, default 64, width of r/w data; strobe width is DATA_W/8.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have ports io_m_ar_valid/addr/len/size/burst  input  2/2*ADDR_W/16/6/4  per-master read address, master N in slice N.
REQ-006 SHALL have port io_m_ar_ready  output  2  per-master read-address accept.
REQ-007 SHALL have ports io_m_r_valid/data/last  output  2/DATA_W/1  read beat; data and last are shared, valid is per master.
REQ-008 SHALL have port io_m_r_ready  input  2  per-master read accept.
REQ-009 SHALL have ports io_m_aw_valid/addr/len/size/burst  input  2/2*ADDR_W/16/6/4  per-master write address.
REQ-010 SHALL have port io_m_aw_ready  output  2  per-master write-address accept.
REQ-011 SHALL have ports io_m_w_valid/data/strb/last  input  2/2*DATA_W/2*DATA_W/8/2  per-master write beat.
REQ-012 SHALL have port io_m_w_ready  output  2  per-master write-beat accept.
REQ-013 SHALL have ports io_m_b_valid  output  2 and io_m_b_ready  input  2  write-done handshake.
REQ-014 SHALL have slave ports io_Sram_ar_*, io_Sram_r_*, io_Sram_aw_*, io_Sram_w_*, io_ar_len/size/burst and io_aw_len/size/burst, matching the SRAM slave one-to-one with opposite direction.
REQ-015 SHALL have port io_err  output  1  sticky w_last/beat-count mismatch flag.

Function
REQ-016 The read path SHALL use a two-state FSM, R_IDLE and R_BUSY, independent of the write path; a read and a write SHALL proceed concurrently.
REQ-017 In R_IDLE the winner SHALL be the only valid requester, or rprio when both are valid.
REQ-018 In R_IDLE, io_Sram_ar_valid SHALL equal OR of io_m_ar_valid; address, len, size and burst SHALL be muxed from the winner; io_m_ar_ready[winner] SHALL equal io_Sram_ar_ready; the loser's ar_ready SHALL be 0.
REQ-019 An ar handshake SHALL register rowner=winner and move to R_BUSY at the next edge; the arbiter SHALL add zero cycles of address latency.
REQ-020 In R_BUSY: io_Sram_ar_valid=0, io_m_ar_ready=0, io_m_r_valid[rowner]=io_Sram_r_valid, io_m_r_valid[other]=0, io_Sram_r_ready=io_m_r_ready[rowner]; data and last SHALL pass through combinationally.
REQ-021 A handshake with r_last=1 SHALL move the FSM to R_IDLE and set rprio=~rowner, giving one idle cycle between bursts.
REQ-022 The write path SHALL use states W_IDLE, W_DATA and W_RESP, with wprio, wowner and the arbitration rules of REQ-017/018 applied to aw.
REQ-023 An aw handshake SHALL load the 8-bit wcnt with aw_len and move to W_DATA.
REQ-024 In W_DATA: io_Sram_w_valid=io_m_w_valid[wowner], data and strb muxed from wowner, io_m_w_ready[wowner]=io_Sram_w_ready, other w_ready=0.
REQ-025 Each w handshake SHALL decrement wcnt; a handshake with wcnt==0 SHALL move to W_RESP.
REQ-026 On any w handshake where io_m_w_last[wowner] != (wcnt==0), io_err SHALL set and hold until reset; wcnt alone SHALL decide burst end.
REQ-027 In W_RESP, io_m_b_valid[wowner]=1 SHALL hold until io_m_b_ready[wowner]; then the FSM SHALL move to W_IDLE and set wprio=~wowner.
REQ-028 The aw_ready of both masters SHALL be 0 in W_DATA and W_RESP.
REQ-029 Len values above 255 are unsupported; only len[7:0] SHALL be forwarded.

Reset
REQ-030 Reset asserted SHALL immediately force R_IDLE and W_IDLE, rowner=wowner=0, rprio=wprio=0 (m0 favoured), wcnt=0, io_err=0, all io_m_b_valid=0.
REQ-031 A reset mid-burst SHALL abandon the burst, and no beat SHALL reach any master after release until a new ar handshake.

Structure
REQ-032 FSM state encodings and the AXI size/burst constants SHALL live in a shared package, ysyx_22050550_axi_pkg.
REQ-033 Arbitration SHALL be one sub-module, ysyx_22050550_rr_arb2 (2 requests, prio in, one-hot grant out), instantiated once each for read and write.

Verification
REQ-034 m0 ar addr 0x80000000 len 3 size 3 -> forwarded same cycle; 4 beats to m0, last on 4th; io_m_r_valid[1]=0 throughout; R_IDLE next cycle.
REQ-035 m0 and m1 ar_valid together after reset -> m0 granted, m1 ar_ready=0; m1 granted in the R_IDLE cycle after m0's last beat; rprio ends at 0.
REQ-036 m1 aw len 1 with two w beats (last on 2nd) -> b_valid[1] the cycle after the 2nd beat, held 3 cycles until b_ready; io_err=0; m0 aw_ready=0 throughout.
REQ-037 m0 read len 3 concurrent with m1 write len 0 -> both complete with no added stall versus running alone.
REQ-038 m1 w_last=1 on beat 1 of a len 1 write -> io_err=1, burst still takes 2 beats, io_err stays 1 until reset.
REQ-039 reset=0 during beat 2 of a len 3 read -> all valids 0 immediately; after release, no r_valid until a new ar.
